// File: rtl/pin_checker_responder.sv
`timescale 1ns/1ps
// pin_checker_responder
//
// Emulated MCU victim for the CM guess protocol. It generates the
// interconnect clock, announces readiness with BEGIN_GUESSING, collects
// framed guesses, and answers YES/NO. The answer is delayed by an amount
// that grows with the number of leading matching bytes. This early-exit
// compare is the timing side channel that the guessing side measures.
//
// Ports
//   CLK_50       in   sole clock
//   SW           in   synchronous active-high reset
//   CLK_inter    out  interconnect clock, CLK_DIV_HALF CLK_50 cycles per half-period
//   CM[7:0]      io   shared byte bus; driven only while announcing or replying
//   unlocked     out  sticky, set when a YES reply completes
//   attempts     out  completed guess frames (saturating)
//   frame_errors out  frames with a bad END byte (saturating)
//   LED[7:0]     out  attempts[7:0]
module pin_checker_responder #(
  parameter int                     CODE_LEN     = 2,
  parameter logic [CODE_LEN*8-1:0]  SECRET       = 16'hA73C,
  parameter int                     CLK_DIV_HALF = 4,
  parameter int                     BASE_DELAY   = 100,
  parameter int                     STEP_DELAY   = 1000
) (
  input  logic        CLK_50,
  input  logic        SW,
  output logic        CLK_inter,
  inout  wire  [7:0]  CM,
  output logic        unlocked,
  output logic [15:0] attempts,
  output logic [7:0]  frame_errors,
  output logic [7:0]  LED
);

  localparam int DIV_W     = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
  localparam int IDX_W     = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int TOTAL_MAX = BASE_DELAY + CODE_LEN * STEP_DELAY;
  localparam int DLY_W     = $clog2(TOTAL_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV_HALF - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
  localparam logic [DLY_W-1:0] FIRST_TGT = DLY_W'(BASE_DELAY + STEP_DELAY);
  localparam logic [DLY_W-1:0] STEP_TGT  = DLY_W'(STEP_DELAY);

  localparam logic [7:0] START_BYTE     = 8'h01;
  localparam logic [7:0] BEGIN_GUESSING = 8'h02;
  localparam logic [7:0] YES_BYTE       = 8'h03;
  localparam logic [7:0] NO_BYTE        = 8'h04;
  localparam logic [7:0] END_BYTE       = 8'h05;

  typedef enum logic [2:0] {
    S_ANNOUNCE,
    S_WAIT_START,
    S_RX_GUESS,
    S_RX_END,
    S_CHECK,
    S_REPLY_WAIT,
    S_REPLY
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Clock divider and slot events
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_clk_inter;
  logic             w_wrap;
  logic             w_rise;
  logic             w_fall;

  assign w_wrap = (r_div_cnt == DIV_LAST);
  // Events fire in the CLK_50 cycle whose closing edge flips CLK_inter.
  assign w_rise = w_wrap & ~r_clk_inter;
  assign w_fall = w_wrap &  r_clk_inter;

  always_ff @(posedge CLK_50) begin
    if (SW) begin
      r_div_cnt   <= '0;
      r_clk_inter <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt   <= '0;
      r_clk_inter <= ~r_clk_inter;
    end else begin
      r_div_cnt   <= r_div_cnt + 1'b1;
    end
  end

  // Protocol state
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_mismatch;
  logic [DLY_W-1:0] r_delay_cnt;
  logic [DLY_W-1:0] r_target;
  logic             r_cm_oe;
  logic [7:0]       r_cm_val;
  logic             r_unlocked;
  logic [15:0]      r_attempts;
  logic [7:0]       r_ferr;
  logic [7:0]       r_guess [CODE_LEN];

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_mismatch_nxt;
  logic [DLY_W-1:0] w_delay_nxt;
  logic [DLY_W-1:0] w_target_nxt;
  logic             w_oe_nxt;
  logic [7:0]       w_val_nxt;
  logic             w_unlocked_nxt;
  logic [15:0]      w_attempts_nxt;
  logic [7:0]       w_ferr_nxt;
  logic             w_guess_we;

  logic [7:0]       w_cm_in;
  logic [7:0]       w_secret [CODE_LEN];
  logic             w_byte_ok;

  assign w_cm_in = CM;
  assign CM      = r_cm_oe ? r_cm_val : 8'bz;

  always_comb begin
    for (int i = 0; i < CODE_LEN; i++) begin
      w_secret[i] = SECRET[i*8 +: 8];
    end
  end

  assign w_byte_ok = (r_guess[r_idx] == w_secret[r_idx]);

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_mismatch_nxt = r_mismatch;
    w_delay_nxt    = r_delay_cnt;
    w_target_nxt   = r_target;
    w_oe_nxt       = r_cm_oe;
    w_val_nxt      = r_cm_val;
    w_unlocked_nxt = r_unlocked;
    w_attempts_nxt = r_attempts;
    w_ferr_nxt     = r_ferr;
    w_guess_we     = 1'b0;

    case (r_state)
      S_ANNOUNCE: begin
        // The drive enable doubles as the "already announcing" marker.
        if (w_fall) begin
          if (!r_cm_oe) begin
            w_oe_nxt  = 1'b1;
            w_val_nxt = BEGIN_GUESSING;
          end else begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = S_WAIT_START;
          end
        end
      end

      S_WAIT_START: begin
        if (w_rise && (w_cm_in == START_BYTE)) begin
          w_idx_nxt      = '0;
          w_mismatch_nxt = 1'b0;
          w_state_nxt    = S_RX_GUESS;
        end
      end

      S_RX_GUESS: begin
        if (w_rise) begin
          w_guess_we = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_RX_END;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end

      S_RX_END: begin
        if (w_rise) begin
          if (w_cm_in == END_BYTE) begin
            w_idx_nxt    = '0;
            w_delay_nxt  = '0;
            w_target_nxt = FIRST_TGT;
            w_state_nxt  = S_CHECK;
          end else begin
            w_ferr_nxt  = sat_inc8(r_ferr);
            w_state_nxt = S_WAIT_START;
          end
        end
      end

      S_CHECK: begin
        // r_target is the cycle count at which the current byte's dwell
        // ends; the verdict for that byte is taken there, so a mismatch
        // at byte k finishes after BASE_DELAY + (k+1)*STEP_DELAY cycles.
        w_delay_nxt = r_delay_cnt + 1'b1;
        if ((r_delay_cnt + 1'b1) == r_target) begin
          if (!w_byte_ok || (r_idx == LAST_IDX)) begin
            w_mismatch_nxt = ~w_byte_ok;
            w_attempts_nxt = sat_inc16(r_attempts);
            // If the finish lands on a fall event, drive immediately
            // rather than losing a whole slot in REPLY_WAIT.
            if (w_fall) begin
              w_oe_nxt    = 1'b1;
              w_val_nxt   = w_byte_ok ? YES_BYTE : NO_BYTE;
              w_state_nxt = S_REPLY;
            end else begin
              w_state_nxt = S_REPLY_WAIT;
            end
          end else begin
            w_idx_nxt    = r_idx + 1'b1;
            w_target_nxt = r_target + STEP_TGT;
          end
        end
      end

      S_REPLY_WAIT: begin
        if (w_fall) begin
          w_oe_nxt    = 1'b1;
          w_val_nxt   = r_mismatch ? NO_BYTE : YES_BYTE;
          w_state_nxt = S_REPLY;
        end
      end

      S_REPLY: begin
        if (w_fall) begin
          w_oe_nxt = 1'b0;
          if (!r_mismatch) begin
            w_unlocked_nxt = 1'b1;
          end
          w_state_nxt = S_WAIT_START;
        end
      end

      default: begin
        w_state_nxt = S_ANNOUNCE;
      end
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (SW) begin
      r_state    <= S_ANNOUNCE;
      r_idx      <= '0;
      r_mismatch <= 1'b0;
      r_cm_oe    <= 1'b0;
      r_unlocked <= 1'b0;
      r_attempts <= '0;
      r_ferr     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_cm_oe    <= w_oe_nxt;
      r_unlocked <= w_unlocked_nxt;
      r_attempts <= w_attempts_nxt;
      r_ferr     <= w_ferr_nxt;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge CLK_50) begin
    r_delay_cnt <= w_delay_nxt;
    r_target    <= w_target_nxt;
    r_cm_val    <= w_val_nxt;
    if (w_guess_we) begin
      r_guess[r_idx] <= w_cm_in;
    end
  end

  assign CLK_inter    = r_clk_inter;
  assign unlocked     = r_unlocked;
  assign attempts     = r_attempts;
  assign frame_errors = r_ferr;
  assign LED          = r_attempts[7:0];

endmodule

// File: tb/tb_pin_checker_responder.sv
`timescale 1ns/1ps
// tb_pin_checker_responder
//
// Acts as the guessing master on CM. It drives frame bytes on CLK_inter
// falling edges and watches the bus on rising edges. Expected replies,
// delays and counters come from a table of hand-derived vectors and from
// a byte-match reference model used for the random frames.
module tb_pin_checker_responder;

  localparam int H    = 4;
  localparam int BASE = 100;
  localparam int STEP = 1000;
  localparam int CL   = 2;

  logic        clk = 1'b0;
  logic        sw;
  logic        clk_inter;
  wire  [7:0]  cm;
  logic        tb_en;
  logic [7:0]  tb_val;
  logic        unlocked;
  logic [15:0] attempts;
  logic [7:0]  ferr;
  logic [7:0]  led;

  always #5 clk = ~clk;

  assign cm = tb_en ? tb_val : 8'bz;

  pin_checker_responder #(
    .CODE_LEN     (CL),
    .SECRET       (16'hA73C),
    .CLK_DIV_HALF (H),
    .BASE_DELAY   (BASE),
    .STEP_DELAY   (STEP)
  ) dut (
    .CLK_50       (clk),
    .SW           (sw),
    .CLK_inter    (clk_inter),
    .CM           (cm),
    .unlocked     (unlocked),
    .attempts     (attempts),
    .frame_errors (ferr),
    .LED          (led)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [7:0] secret_b [CL];
  int         m_attempts;
  int         m_ferr;
  bit         m_unlocked;

  typedef struct {
    logic [7:0] g0;
    logic [7:0] g1;
    logic [7:0] endb;
    bit         exp_rep;
    logic [7:0] exp_val;
    int         exp_total;
  } vec_t;

  vec_t vecs [5];
  int   dly  [5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input longint act, input longint lo, input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic bit released();
    return (cm === 8'hzz) || (cm === 8'h00);
  endfunction

  // Reply is decided by how many leading bytes match the secret.
  function automatic void ref_reply(input logic [7:0] g0, input logic [7:0] g1,
                                    output bit yes, output int total);
    logic [7:0] g [CL];
    int  k;
    bit  stop;
    g[0] = g0;
    g[1] = g1;
    k    = 0;
    stop = 0;
    for (int i = 0; i < CL; i++) begin
      if (!stop) begin
        if (g[i] == secret_b[i]) k++;
        else stop = 1;
      end
    end
    yes   = (k == CL);
    total = BASE + (yes ? CL : k + 1) * STEP;
  endfunction

  task automatic send_frame(input logic [7:0] g0, input logic [7:0] g1,
                            input logic [7:0] endb, output int t_end);
    logic [7:0] seq [4];
    seq[0] = 8'h01;
    seq[1] = g0;
    seq[2] = g1;
    seq[3] = endb;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_inter);
      tb_en  = 1'b1;
      tb_val = seq[i];
    end
    @(posedge clk_inter);
    #1;
    t_end = cyc;
    @(negedge clk_inter);
    tb_en = 1'b0;
  endtask

  task automatic wait_reply(input int max_slots, output logic [7:0] v,
                            output int t_rep, output bit got);
    got   = 0;
    v     = 8'h00;
    t_rep = 0;
    for (int s = 0; s < max_slots; s++) begin
      if (!got) begin
        @(posedge clk_inter);
        #1;
        if (cm === 8'h03 || cm === 8'h04) begin
          got   = 1;
          v     = cm;
          t_rep = cyc;
        end
      end
    end
  endtask

  task automatic check_announce(input string nm);
    bit found;
    int ta;
    int tb;
    found = 0;
    ta    = 0;
    for (int s = 0; s < 6; s++) begin
      if (!found) begin
        @(posedge clk_inter);
        #1;
        if (cm === 8'h02) begin
          found = 1;
          ta    = cyc;
        end
      end
    end
    chk({nm, " announce 0x02 seen"}, found, 1);
    @(posedge clk_inter);
    #1;
    tb = cyc;
    chk({nm, " announce released"}, released(), 1);
    if (found) chk({nm, " CLK_inter period"}, tb - ta, 2 * H);
  endtask

  task automatic run_frame(input logic [7:0] g0, input logic [7:0] g1, input logic [7:0] endb,
                           input bit exp_rep, input logic [7:0] exp_val, input int exp_total,
                           input string nm, output int delay);
    int         t_end;
    int         t_rep;
    logic [7:0] v;
    bit         got;
    send_frame(g0, g1, endb, t_end);
    delay = 0;
    if (exp_rep) begin
      wait_reply(400, v, t_rep, got);
      chk({nm, " reply seen"}, got, 1);
      if (got) begin
        chk({nm, " reply value"}, v, exp_val);
        delay = t_rep - t_end;
        chk_range({nm, " reply delay"}, delay, exp_total, exp_total + 2 * H);
      end
      @(negedge clk_inter);
      #1;
      if (m_attempts < 65535) m_attempts++;
      if (exp_val == 8'h03) m_unlocked = 1;
      chk({nm, " bus released after reply"}, released(), 1);
      chk({nm, " unlocked"}, unlocked, m_unlocked);
      chk({nm, " attempts"}, attempts, m_attempts);
      chk({nm, " LED"}, led, m_attempts % 256);
    end else begin
      wait_reply(300, v, t_rep, got);
      chk({nm, " no reply"}, got, 0);
      if (m_ferr < 255) m_ferr++;
      chk({nm, " frame_errors"}, ferr, m_ferr);
      chk({nm, " attempts unchanged"}, attempts, m_attempts);
      chk({nm, " bus released"}, released(), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         d;
    int         t_end;
    int         t_rep;
    bit         got;
    bit         yes;
    int         total;
    int         mode;
    logic [7:0] g0;
    logic [7:0] g1;
    logic [7:0] eb;
    logic [7:0] v;

    secret_b[0] = 8'h3C;
    secret_b[1] = 8'hA7;
    m_attempts  = 0;
    m_ferr      = 0;
    m_unlocked  = 0;

    vecs[0] = '{g0: 8'h00, g1: 8'hA7, endb: 8'h05, exp_rep: 1, exp_val: 8'h04, exp_total: 1100};
    vecs[1] = '{g0: 8'h3C, g1: 8'h00, endb: 8'h05, exp_rep: 1, exp_val: 8'h04, exp_total: 2100};
    vecs[2] = '{g0: 8'h3C, g1: 8'hA7, endb: 8'h07, exp_rep: 0, exp_val: 8'h00, exp_total: 0};
    vecs[3] = '{g0: 8'hA7, g1: 8'h3C, endb: 8'h05, exp_rep: 1, exp_val: 8'h04, exp_total: 1100};
    vecs[4] = '{g0: 8'h3C, g1: 8'hA7, endb: 8'h05, exp_rep: 1, exp_val: 8'h03, exp_total: 2100};

    // Reset state
    sw     = 1'b1;
    tb_en  = 1'b0;
    tb_val = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset CLK_inter", clk_inter, 0);
    chk("reset unlocked", unlocked, 0);
    chk("reset attempts", attempts, 0);
    chk("reset frame_errors", ferr, 0);
    chk("reset LED", led, 0);
    chk("reset bus released", released(), 1);
    @(negedge clk);
    sw = 1'b0;
    check_announce("boot");

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].g0, vecs[i].g1, vecs[i].endb, vecs[i].exp_rep,
                vecs[i].exp_val, vecs[i].exp_total, $sformatf("tbl%0d", i), dly[i]);
    end
    chk_range("leak step byte0-right vs byte0-wrong", dly[1] - dly[0], STEP - 2 * H, STEP + 2 * H);

    // Random frames against the reference model
    for (int r = 0; r < 10; r++) begin
      mode = int'($urandom_range(0, 2));
      g0   = (mode == 2) ? 8'($urandom_range(0, 255)) : 8'h3C;
      g1   = (mode == 0) ? 8'hA7 : 8'($urandom_range(0, 255));
      eb   = 8'h05;
      if ($urandom_range(0, 4) == 0) begin
        eb = 8'($urandom_range(0, 255));
        if (eb == 8'h05) eb = 8'h06;
      end
      ref_reply(g0, g1, yes, total);
      run_frame(g0, g1, eb, (eb == 8'h05), yes ? 8'h03 : 8'h04, total,
                $sformatf("rnd%0d", r), d);
    end

    // Reset in the middle of CHECK
    send_frame(8'h3C, 8'hA7, 8'h05, t_end);
    repeat (500) @(posedge clk);
    @(negedge clk);
    sw = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset bus released", released(), 1);
    chk("midreset attempts", attempts, 0);
    chk("midreset frame_errors", ferr, 0);
    chk("midreset unlocked", unlocked, 0);
    chk("midreset CLK_inter", clk_inter, 0);
    m_attempts = 0;
    m_ferr     = 0;
    m_unlocked = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sw = 1'b0;
    check_announce("midreset");
    wait_reply(300, v, t_rep, got);
    chk("midreset no stale reply", got, 0);
    run_frame(8'h3C, 8'hA7, 8'h05, 1, 8'h03, 2100, "post-reset yes", d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
